bus_rr_arbiter: RTL and testbench

Round-robin arbiter for the shared serial bus (b_BUS / b_RW / b_bus_utilizing). It grants ownership to one of up to 16 masters and tracks the transaction through the open-drain bus-utilization line. It also enforces two watchdogs: a granted master that never starts, and a master that holds the bus too long. It sits beside the bus controller at top level and drives the masters' b_grant inputs directly.

---
 rtl/bus_rr_arbiter.sv | 140 ++++++++++++++
 tb/tb_bus_rr_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_rr_arbiter.sv
// Round-robin owner arbiter for the shared serial bus.
// Tracks each grant through b_bus_utilizing and enforces start/hold watchdogs.
module bus_rr_arbiter #(
  parameter int NUM_MASTERS = 12,
  parameter int START_LEN   = 4,
  parameter int HOLD_LEN    = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NUM_MASTERS-1:0] m_reqs,
  input  logic                   bus_util,
  output logic [NUM_MASTERS-1:0] m_grants,
  output logic [3:0]             mid_current,
  output logic                   bus_busy,
  output logic                   timeout_err,
  output logic [2:0]             state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_GRANT = 3'd1;
  localparam logic [2:0] S_BUSY  = 3'd2;
  localparam logic [2:0] S_REL   = 3'd3;

  localparam int CW = (START_LEN > HOLD_LEN) ? START_LEN : HOLD_LEN;
  localparam logic [CW-1:0] START_MAX = CW'((1 << START_LEN) - 1);
  localparam logic [CW-1:0] HOLD_MAX  = CW'((1 << HOLD_LEN) - 1);

  logic [2:0]             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [3:0]             mid_q, mid_d;
  logic [3:0]             ptr_q, ptr_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   busy_q, busy_d;
  logic                   err_q, err_d;

  logic [NUM_MASTERS-1:0] win_vec;
  logic [3:0]             win_idx;
  logic [CW-1:0]          cnt_inc;
  logic                   own_req;
  int                     best_d;

  // Winner is the requester with the smallest forward distance from ptr+1.
  always_comb begin
    best_d  = NUM_MASTERS;
    win_idx = '0;
    win_vec = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (m_reqs[i] &&
          ((i + NUM_MASTERS - 1 - int'(ptr_q)) % NUM_MASTERS) < best_d) begin
        best_d  = (i + NUM_MASTERS - 1 - int'(ptr_q)) % NUM_MASTERS;
        win_idx = 4'(i);
        win_vec = '0;
        win_vec[i] = 1'b1;
      end
    end
  end

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
  assign own_req = |(m_reqs & grant_q);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    mid_d   = mid_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|m_reqs) begin
          state_d = S_GRANT;
          grant_d = win_vec;
          mid_d   = win_idx;
          cnt_d   = '0;
        end
      end
      S_GRANT: begin
        cnt_d = cnt_inc;
        if (!bus_util) begin
          state_d = S_BUSY;
          cnt_d   = '0;
        end else if (!own_req) begin
          state_d = S_REL;
          grant_d = '0;
        end else if (cnt_q == START_MAX) begin
          state_d = S_REL;
          grant_d = '0;
          err_d   = 1'b1;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_inc;
        if (bus_util) begin
          state_d = S_REL;
          grant_d = '0;
        end else if (cnt_q == HOLD_MAX) begin
          state_d = S_REL;
          grant_d = '0;
          err_d   = 1'b1;
        end
      end
      S_REL: begin
        ptr_d   = mid_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
    busy_d = (state_d == S_GRANT) || (state_d == S_BUSY);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      mid_q   <= '0;
      ptr_q   <= 4'(NUM_MASTERS - 1);
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      mid_q   <= mid_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign m_grants    = grant_q;
  assign mid_current = mid_q;
  assign bus_busy    = busy_q;
  assign timeout_err = err_q;
  assign state       = state_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Bench for bus_rr_arbiter: directed scenarios plus random traffic
// compared against a phase/elapsed-time model of the arbiter.
module tb_bus_rr_arbiter;

  localparam int N  = 12;
  localparam int SL = 4;
  localparam int HL = 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [N-1:0]  m_reqs = '0;
  logic          bus_util = 1'b1;
  logic [N-1:0]  m_grants;
  logic [3:0]    mid_current;
  logic          bus_busy;
  logic          timeout_err;
  logic [2:0]    state;
  logic [20:0]   dut_v;

  int nvec = 0;
  int nmis = 0;

  // model: phase (0 idle,1 grant,2 busy,3 release), owner, pointer, elapsed
  int         ph = 0;
  logic [3:0] own = '0;
  int         mptr = N - 1;
  int         el = 0;
  logic       e_err = 1'b0;

  bus_rr_arbiter #(.NUM_MASTERS(N), .START_LEN(SL), .HOLD_LEN(HL)) dut (
    .clk(clk), .rstn(rstn), .m_reqs(m_reqs), .bus_util(bus_util),
    .m_grants(m_grants), .mid_current(mid_current), .bus_busy(bus_busy),
    .timeout_err(timeout_err), .state(state)
  );

  always #5 clk = ~clk;

  assign dut_v = {m_grants, mid_current, bus_busy, timeout_err, state};

  function automatic int pick(input logic [N-1:0] r, input int p);
    logic [3:0] ci;
    for (int s = 1; s <= N; s++) begin
      ci = 4'((p + s) % N);
      if (r[ci]) return int'(ci);
    end
    return p;
  endfunction

  function automatic logic [20:0] expv();
    logic [N-1:0] g;
    logic         b;
    g = '0;
    b = (ph == 1) || (ph == 2);
    if (b) g[own] = 1'b1;
    return {g, own, b, e_err, 3'(ph)};
  endfunction

  task automatic model_edge(input logic [N-1:0] r, input logic u,
                            input logic rs);
    e_err = 1'b0;
    if (!rs) begin
      ph = 0; own = '0; mptr = N - 1; el = 0;
    end else begin
      case (ph)
        0: if (r != '0) begin
          own = 4'(pick(r, mptr)); ph = 1; el = 0;
        end
        1: begin
          el++;
          if (!u) begin ph = 2; el = 0; end
          else if (!r[own]) ph = 3;
          else if (el == (1 << SL)) begin ph = 3; e_err = 1'b1; end
        end
        2: begin
          el++;
          if (u) ph = 3;
          else if (el == (1 << HL)) begin ph = 3; e_err = 1'b1; end
        end
        default: begin mptr = int'(own); ph = 0; end
      endcase
    end
  endtask

  task automatic tick(input logic [N-1:0] r, input logic u, input logic rs);
    m_reqs = r; bus_util = u; rstn = rs;
    @(posedge clk);
    model_edge(r, u, rs);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) begin
      tick('0, 1'b1, 1'b0);
      nvec++;
      if (dut_v !== expv()) begin
        nmis++; $display("FAIL reset_model got %h exp %h", dut_v, expv());
      end
    end
    nvec++;
    if (dut_v !== 21'h0) begin
      nmis++; $display("FAIL reset_vals got %h exp %h", dut_v, 21'h0);
    end
    tick(12'h004, 1'b1, 1'b1);
    nvec++;
    if (m_grants !== 12'h004 || mid_current !== 4'd2) begin
      nmis++;
      $display("FAIL first_grant got %h/%0d exp 004/2", m_grants, mid_current);
    end
    for (int i = 0; i < 20; i++) begin
      tick(12'h004, 1'b0, 1'b1);
      nvec++;
      if (dut_v !== expv()) begin
        nmis++; $display("FAIL busy_model got %h exp %h", dut_v, expv());
      end
      if (i == 0) begin
        nvec++;
        if (state !== 3'd2) begin
          nmis++; $display("FAIL busy_entry got %0d exp 2", state);
        end
      end
    end
    tick('0, 1'b1, 1'b1);
    nvec++;
    if (state !== 3'd3 || m_grants !== 12'h0) begin
      nmis++; $display("FAIL release got %0d/%h exp 3/000", state, m_grants);
    end
    tick('0, 1'b1, 1'b1);
    nvec++;
    if (state !== 3'd0 || m_grants !== 12'h0) begin
      nmis++; $display("FAIL idle_after got %0d/%h exp 0/000", state, m_grants);
    end
  endtask

  task automatic test_fairness();
    int   order[$];
    int   exp_order[6] = '{2, 4, 5, 2, 4, 5};
    logic u;
    logic prev_busy;
    tick('0, 1'b1, 1'b0);
    prev_busy = 1'b0;
    for (int c = 0; c < 300 && order.size() < 6; c++) begin
      u = !((ph == 1) || (ph == 2 && el < 4));
      tick(12'h034, u, 1'b1);
      nvec++;
      if (dut_v !== expv()) begin
        nmis++; $display("FAIL fair_model got %h exp %h", dut_v, expv());
      end
      if (bus_busy && !prev_busy) order.push_back(int'(mid_current));
      prev_busy = bus_busy;
    end
    for (int i = 0; i < 6; i++) begin
      nvec++;
      if (i >= order.size()) begin
        nmis++; $display("FAIL fair_order[%0d] got none exp %0d", i,
                         exp_order[i]);
      end else if (order[i] != exp_order[i]) begin
        nmis++; $display("FAIL fair_order[%0d] got %0d exp %0d", i,
                         order[i], exp_order[i]);
      end
    end
    repeat (4) tick('0, 1'b1, 1'b1);
    nvec++;
    if (dut_v !== expv()) begin
      nmis++; $display("FAIL fair_drain got %h exp %h", dut_v, expv());
    end
  endtask

  task automatic test_start_timeout();
    int fire_at = -1;
    int pulses = 0;
    tick(12'h010, 1'b1, 1'b1);
    nvec++;
    if (m_grants !== 12'h010) begin
      nmis++; $display("FAIL st_grant got %h exp 010", m_grants);
    end
    for (int i = 1; i <= 24; i++) begin
      tick((fire_at < 0) ? 12'h010 : 12'h000, 1'b1, 1'b1);
      nvec++;
      if (dut_v !== expv()) begin
        nmis++; $display("FAIL st_model got %h exp %h", dut_v, expv());
      end
      if (timeout_err === 1'b1) begin
        pulses++;
        if (fire_at < 0) begin
          fire_at = i;
          nvec++;
          if (m_grants !== 12'h0) begin
            nmis++; $display("FAIL st_drop got %h exp 000", m_grants);
          end
        end
      end
    end
    nvec++;
    if (fire_at != 16 || pulses != 1) begin
      nmis++;
      $display("FAIL st_timing got at=%0d n=%0d exp at=16 n=1", fire_at, pulses);
    end
    tick(12'h011, 1'b1, 1'b1);
    nvec++;
    if (mid_current !== 4'd0 || m_grants !== 12'h001) begin
      nmis++;
      $display("FAIL st_ptr got %0d/%h exp 0/001", mid_current, m_grants);
    end
    repeat (2) tick('0, 1'b1, 1'b1);
  endtask

  task automatic test_hold_timeout();
    int n = 0;
    tick(12'h020, 1'b1, 1'b1);
    nvec++;
    if (mid_current !== 4'd5) begin
      nmis++; $display("FAIL ht_grant got %0d exp 5", mid_current);
    end
    tick(12'h020, 1'b0, 1'b1);
    for (int i = 0; i < 300; i++) begin
      tick(12'h020, 1'b0, 1'b1);
      n++;
      nvec++;
      if (dut_v !== expv()) begin
        nmis++; $display("FAIL ht_model got %h exp %h", dut_v, expv());
      end
      if (timeout_err === 1'b1) break;
    end
    nvec++;
    if (n != 256 || state !== 3'd3 || m_grants !== 12'h0) begin
      nmis++;
      $display("FAIL ht_timing got n=%0d st=%0d exp n=256 st=3", n, state);
    end
    tick('0, 1'b1, 1'b1);
  endtask

  task automatic test_withdraw();
    tick(12'h004, 1'b1, 1'b1);
    repeat (2) tick(12'h004, 1'b1, 1'b1);
    tick('0, 1'b1, 1'b1);
    nvec++;
    if (state !== 3'd3 || timeout_err !== 1'b0) begin
      nmis++;
      $display("FAIL wd_release got %0d/%b exp 3/0", state, timeout_err);
    end
    tick('0, 1'b1, 1'b1);
    tick(12'h004, 1'b1, 1'b1);
    repeat (15) tick(12'h004, 1'b1, 1'b1);
    nvec++;
    if (state !== 3'd1) begin
      nmis++; $display("FAIL edge_hold got %0d exp 1", state);
    end
    tick(12'h004, 1'b0, 1'b1);
    nvec++;
    if (state !== 3'd2 || timeout_err !== 1'b0) begin
      nmis++;
      $display("FAIL edge_busy got %0d/%b exp 2/0", state, timeout_err);
    end
    tick('0, 1'b1, 1'b1);
    tick('0, 1'b1, 1'b1);
    nvec++;
    if (dut_v !== expv()) begin
      nmis++; $display("FAIL edge_model got %h exp %h", dut_v, expv());
    end
  endtask

  task automatic test_reset_mid();
    tick(12'h020, 1'b1, 1'b1);
    repeat (3) tick(12'h020, 1'b0, 1'b1);
    nvec++;
    if (state !== 3'd2) begin
      nmis++; $display("FAIL rm_busy got %0d exp 2", state);
    end
    tick(12'h020, 1'b0, 1'b0);
    nvec++;
    if (dut_v !== 21'h0) begin
      nmis++; $display("FAIL rm_reset got %h exp %h", dut_v, 21'h0);
    end
    tick(12'h021, 1'b1, 1'b1);
    nvec++;
    if (mid_current !== 4'd0 || m_grants !== 12'h001) begin
      nmis++;
      $display("FAIL rm_first got %0d/%h exp 0/001", mid_current, m_grants);
    end
    repeat (2) tick('0, 1'b1, 1'b1);
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    logic         u;
    logic         rs;
    int           len;
    int           mode;
    for (int seg = 0; seg < 150; seg++) begin
      r    = N'($urandom & $urandom);
      len  = int'($urandom_range(1, 40));
      mode = int'($urandom_range(0, 2));
      for (int c = 0; c < len; c++) begin
        u  = (mode == 0) ? 1'($urandom) : (mode == 1);
        rs = ($urandom_range(0, 399) != 0);
        if ($urandom_range(0, 9) == 0) r = N'($urandom);
        tick(r, u, rs);
        nvec++;
        if (dut_v !== expv()) begin
          nmis++; $display("FAIL rand_model got %h exp %h", dut_v, expv());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_start_timeout();
    test_hold_timeout();
    test_withdraw();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
